csr_file: RTL and testbench

Machine-mode CSR register file for the RV32 core, sitting in writeback as the consumer of the `csr_params` bundle produced by CSR decode. It performs the atomic read-modify-write (RW/RS/RC) on the addressed CSR and returns the old value for `rd`. It owns the cycle/instret counters and the trap-state CSRs (`mstatus`, `mepc`, `mcause`, `mtval`, `mtvec`). It also applies trap entry and `mret` updates and exports the values fetch/trap logic needs.

---
 rtl/csr_file.sv | 157 +++++++++++++++
 tb/tb_csr_file.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR file: atomic RW/RS/RC on the addressed CSR, 64-bit cycle/instret
// counters, and trap-entry / mret updates of the trap-state CSRs.
package csr_file_pkg;
  typedef enum logic [1:0] {
    CSR_WRITE_NONE = 2'd0,
    CSR_WRITE_RW   = 2'd1,
    CSR_WRITE_RS   = 2'd2,
    CSR_WRITE_RC   = 2'd3
  } csr_write_func_e;

  typedef struct packed {
    logic            read_enable;
    logic            write_enable;
    csr_write_func_e write_func;
    logic            input_select;
    logic [31:0]     write_value;
  } csr_params;
endpackage

module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] HART_ID = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [11:0] req_addr,
  input  csr_params   req_params,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_illegal,
  input  logic        instret_inc,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_valid,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mstatus_mie_o
);
  logic        mie_q, mpie_q;
  logic [31:0] irq_en_q, mscratch_q, mcause_q, mtval_q;
  logic [31:2] mtvec_q, mepc_q;
  logic [63:0] mcycle_q, minstret_q;
  logic        rsp_valid_q, rsp_illegal_q;
  logic [31:0] rsp_rdata_q;

  logic        known, illegal_d, wr_en;
  logic [31:0] rdata_d, wval_d, v;

  // read_enable and input_select are consumed upstream; old value is always returned
  logic unused_params;
  assign unused_params = req_params.read_enable ^ req_params.input_select;

  assign v = req_params.write_value;

  always_comb begin
    known   = 1'b1;
    rdata_d = 32'd0;
    case (req_addr)
      12'h300: rdata_d = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
      12'h301: rdata_d = 32'h4000_0100;
      12'h304: rdata_d = irq_en_q;
      12'h305: rdata_d = {mtvec_q, 2'b00};
      12'h340: rdata_d = mscratch_q;
      12'h341: rdata_d = {mepc_q, 2'b00};
      12'h342: rdata_d = mcause_q;
      12'h343: rdata_d = mtval_q;
      12'h344: rdata_d = 32'd0;
      12'hB00, 12'hC00: rdata_d = mcycle_q[31:0];
      12'hB80, 12'hC80: rdata_d = mcycle_q[63:32];
      12'hB02, 12'hC02: rdata_d = minstret_q[31:0];
      12'hB82, 12'hC82: rdata_d = minstret_q[63:32];
      12'hF11, 12'hF12, 12'hF13: rdata_d = 32'd0;
      12'hF14: rdata_d = HART_ID;
      default: known = 1'b0;
    endcase

    illegal_d = !known || (req_params.write_enable && req_addr[11:10] == 2'b11);

    case (req_params.write_func)
      CSR_WRITE_RW: wval_d = v;
      CSR_WRITE_RS: wval_d = rdata_d | v;
      CSR_WRITE_RC: wval_d = rdata_d & ~v;
      default:      wval_d = rdata_d;
    endcase

    // trap and mret take the cycle; a concurrent CSR write is dropped
    wr_en = req_valid && !illegal_d && req_params.write_enable &&
            req_params.write_func != CSR_WRITE_NONE && !trap_valid && !mret_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      irq_en_q      <= 32'd0;
      mtvec_q       <= 30'd0;
      mscratch_q    <= 32'd0;
      mepc_q        <= 30'd0;
      mcause_q      <= 32'd0;
      mtval_q       <= 32'd0;
      mcycle_q      <= 64'd0;
      minstret_q    <= 64'd0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      rsp_illegal_q <= 1'b0;
    end else begin
      rsp_valid_q   <= req_valid;
      rsp_rdata_q   <= rdata_d;
      rsp_illegal_q <= req_valid && illegal_d;

      // a write to either half replaces it and holds the counter for this cycle
      if (wr_en && req_addr == 12'hB00)      mcycle_q[31:0]  <= wval_d;
      else if (wr_en && req_addr == 12'hB80) mcycle_q[63:32] <= wval_d;
      else                                   mcycle_q <= mcycle_q + 64'd1;

      if (wr_en && req_addr == 12'hB02)      minstret_q[31:0]  <= wval_d;
      else if (wr_en && req_addr == 12'hB82) minstret_q[63:32] <= wval_d;
      else                                   minstret_q <= minstret_q + {63'd0, instret_inc};

      if (trap_valid) begin
        mepc_q   <= trap_pc[31:2];
        mcause_q <= trap_cause;
        mtval_q  <= trap_tval;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (mret_valid) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (wr_en) begin
        case (req_addr)
          12'h300: begin
            mie_q  <= wval_d[3];
            mpie_q <= wval_d[7];
          end
          12'h304: irq_en_q   <= wval_d;
          12'h305: mtvec_q    <= wval_d[31:2];
          12'h340: mscratch_q <= wval_d;
          12'h341: mepc_q     <= wval_d[31:2];
          12'h342: mcause_q   <= wval_d;
          12'h343: mtval_q    <= wval_d;
          default: ;
        endcase
      end
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_illegal   = rsp_illegal_q;
  assign mtvec_o       = {mtvec_q, 2'b00};
  assign mepc_o        = {mepc_q, 2'b00};
  assign mstatus_mie_o = mie_q;
endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural CSR model.
module tb_csr_file;
  import csr_file_pkg::*;

  logic        clk, reset, req_valid, instret_inc, trap_valid, mret_valid;
  logic [11:0] req_addr;
  csr_params   req_params;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic        rsp_valid, rsp_illegal, mstatus_mie_o;
  logic [31:0] rsp_rdata, mtvec_o, mepc_o;

  int n_checks = 0;
  int n_fail   = 0;

  csr_file #(.HART_ID(32'd0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_params(req_params), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_illegal(rsp_illegal), .instret_inc(instret_inc), .trap_valid(trap_valid),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_valid(mret_valid), .mtvec_o(mtvec_o), .mepc_o(mepc_o),
    .mstatus_mie_o(mstatus_mie_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_live = 1'b0;
  logic        m_mie, m_mpie;
  logic [31:0] m_irq_en, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cyc, m_ins, n_cyc, n_ins;
  logic        e_valid, e_ill, m_known, m_bad, m_do_w;
  logic [31:0] e_rdata, m_old, m_new;

  function automatic logic m_read(input logic [11:0] a, output logic [31:0] val);
    val = 32'd0;
    case (a)
      12'h300: val = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: val = 32'h4000_0100;
      12'h304: val = m_irq_en;
      12'h305: val = m_mtvec;
      12'h340: val = m_mscratch;
      12'h341: val = m_mepc;
      12'h342: val = m_mcause;
      12'h343: val = m_mtval;
      12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14: val = 32'd0;
      12'hB00, 12'hC00: val = m_cyc[31:0];
      12'hB80, 12'hC80: val = m_cyc[63:32];
      12'hB02, 12'hC02: val = m_ins[31:0];
      12'hB82, 12'hC82: val = m_ins[63:32];
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_live = 1'b1;
      {m_mie, m_mpie} = 2'b00;
      m_irq_en = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
      m_cyc = 0; m_ins = 0;
      e_valid = 0; e_rdata = 0; e_ill = 0;
    end else begin
      m_known = m_read(req_addr, m_old);
      m_bad   = !m_known || (req_params.write_enable && req_addr[11:10] == 2'b11);
      e_valid = req_valid;
      e_rdata = m_old;
      e_ill   = req_valid && m_bad;
      case (req_params.write_func)
        CSR_WRITE_RW: m_new = req_params.write_value;
        CSR_WRITE_RS: m_new = m_old | req_params.write_value;
        CSR_WRITE_RC: m_new = m_old & ~req_params.write_value;
        default:      m_new = m_old;
      endcase
      m_do_w = req_valid && !m_bad && req_params.write_enable &&
               req_params.write_func != CSR_WRITE_NONE && !trap_valid && !mret_valid;
      n_cyc = m_cyc + 64'd1;
      n_ins = m_ins + 64'(instret_inc);
      if (m_do_w) begin
        case (req_addr)
          12'h300: begin m_mie = m_new[3]; m_mpie = m_new[7]; end
          12'h304: m_irq_en = m_new;
          12'h305: m_mtvec = m_new & 32'hFFFF_FFFC;
          12'h340: m_mscratch = m_new;
          12'h341: m_mepc = m_new & 32'hFFFF_FFFC;
          12'h342: m_mcause = m_new;
          12'h343: m_mtval = m_new;
          12'hB00: n_cyc = {m_cyc[63:32], m_new};
          12'hB80: n_cyc = {m_new, m_cyc[31:0]};
          12'hB02: n_ins = {m_ins[63:32], m_new};
          12'hB82: n_ins = {m_new, m_ins[31:0]};
          default: ;
        endcase
      end
      if (trap_valid) begin
        m_mepc = trap_pc & 32'hFFFF_FFFC;
        m_mcause = trap_cause;
        m_mtval = trap_tval;
        m_mpie = m_mie;
        m_mie = 1'b0;
      end else if (mret_valid) begin
        m_mie = m_mpie;
        m_mpie = 1'b1;
      end
      m_cyc = n_cyc;
      m_ins = n_ins;
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      if (e_valid) begin
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_illegal", 32'(rsp_illegal), 32'(e_ill));
      end
      chk("mtvec_o", mtvec_o, m_mtvec);
      chk("mepc_o", mepc_o, m_mepc);
      chk("mie_o", 32'(mstatus_mie_o), 32'(m_mie));
    end
  end

  // ---------------- stimulus ----------------
  task automatic req(input logic [11:0] a, input logic we, input csr_write_func_e f,
                     input logic [31:0] val, output logic [31:0] rd, output logic ill,
                     output logic vld);
    req_valid = 1'b1;
    req_addr = a;
    req_params.read_enable = 1'b1;
    req_params.write_enable = we;
    req_params.write_func = f;
    req_params.input_select = 1'b0;
    req_params.write_value = val;
    @(posedge clk);
    #1;
    rd = rsp_rdata;
    ill = rsp_illegal;
    vld = rsp_valid;
  endtask

  logic [31:0] rd;
  logic        ill, vld;
  logic [11:0] addrs [0:27] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
    12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
    12'hC02, 12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h345, 12'hFFF,
    12'h300, 12'h341, 12'h305, 12'h340};

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = 12'h0; req_params = '0;
    instret_inc = 1'b0; trap_valid = 1'b0; mret_valid = 1'b0;
    trap_cause = 0; trap_pc = 0; trap_tval = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset mtvec_o", mtvec_o, 32'd0);
    chk("reset mie_o", 32'(mstatus_mie_o), 32'd0);
    reset = 1'b0;

    // mscratch read-modify-write chain
    req(12'h340, 1, CSR_WRITE_RW, 32'hDEADBEEF, rd, ill, vld); chk("mscratch rw", rd, 32'h0);
    req(12'h340, 1, CSR_WRITE_RS, 32'h10, rd, ill, vld);       chk("mscratch rs", rd, 32'hDEADBEEF);
    req(12'h340, 0, CSR_WRITE_NONE, 0, rd, ill, vld);          chk("mscratch rd", rd, 32'hDEADBEFF);

    // mstatus masking
    req(12'h300, 1, CSR_WRITE_RS, 32'h8, rd, ill, vld);        chk("mstatus set", rd, 32'h1800);
    req(12'h300, 1, CSR_WRITE_RC, 32'h8, rd, ill, vld);        chk("mstatus clr", rd, 32'h1808);
    req(12'h300, 1, CSR_WRITE_RW, 32'hFFFFFFFF, rd, ill, vld); chk("mstatus rw", rd, 32'h1800);
    req(12'h300, 0, CSR_WRITE_NONE, 0, rd, ill, vld);          chk("mstatus rd", rd, 32'h1888);

    // counter carry and write suppression
    req(12'hB80, 1, CSR_WRITE_RW, 32'h0, rd, ill, vld);
    req(12'hB00, 1, CSR_WRITE_RW, 32'hFFFFFFFF, rd, ill, vld);
    req(12'hB80, 0, CSR_WRITE_NONE, 0, rd, ill, vld);          chk("mcycleh pre", rd, 32'd0);
    req(12'hB80, 0, CSR_WRITE_NONE, 0, rd, ill, vld);          chk("mcycleh carry", rd, 32'd1);
    instret_inc = 1'b1;
    req(12'hB82, 1, CSR_WRITE_RW, 32'h7, rd, ill, vld);
    instret_inc = 1'b0;
    req(12'hB02, 0, CSR_WRITE_NONE, 0, rd, ill, vld);          chk("minstret held", rd, 32'd0);
    req(12'hB82, 0, CSR_WRITE_NONE, 0, rd, ill, vld);          chk("minstreth", rd, 32'd7);

    // illegal accesses
    req(12'hC00, 1, CSR_WRITE_RW, 32'h55, rd, ill, vld);       chk("cycle wr ill", 32'(ill), 32'd1);
    req(12'h7C0, 1, CSR_WRITE_RW, 32'h55, rd, ill, vld);       chk("7c0 ill", 32'(ill), 32'd1);
    req(12'hC00, 0, CSR_WRITE_NONE, 0, rd, ill, vld);          chk("cycle rd legal", 32'(ill), 32'd0);
    req(12'h340, 0, CSR_WRITE_NONE, 0, rd, ill, vld);          chk("state kept", rd, 32'hDEADBEFF);

    // trap beats a concurrent mepc write, then mret restores MIE
    trap_valid = 1'b1; trap_pc = 32'h80000102; trap_cause = 32'hB; trap_tval = 32'h77;
    req(12'h341, 1, CSR_WRITE_RW, 32'h1234, rd, ill, vld);
    trap_valid = 1'b0;
    chk("trap rsp rd", rd, 32'h0);
    chk("trap rsp ill", 32'(ill), 32'd0);
    chk("trap mepc_o", mepc_o, 32'h80000100);
    chk("trap mie", 32'(mstatus_mie_o), 32'd0);
    mret_valid = 1'b1;
    req(12'h300, 0, CSR_WRITE_NONE, 0, rd, ill, vld);          chk("trap mstatus", rd, 32'h1880);
    mret_valid = 1'b0;
    chk("mret mie", 32'(mstatus_mie_o), 32'd1);
    req(12'h342, 0, CSR_WRITE_NONE, 0, rd, ill, vld);          chk("mcause", rd, 32'hB);
    req(12'h343, 0, CSR_WRITE_NONE, 0, rd, ill, vld);          chk("mtval", rd, 32'h77);

    // reset in the same cycle as a request
    reset = 1'b1;
    req(12'h340, 1, CSR_WRITE_RW, 32'h99, rd, ill, vld);
    reset = 1'b0;
    chk("rst req vld", 32'(vld), 32'd0);
    chk("rst req rd", rd, 32'd0);
    req(12'h340, 0, CSR_WRITE_NONE, 0, rd, ill, vld);          chk("rst mscratch", rd, 32'd0);
    req(12'h300, 0, CSR_WRITE_NONE, 0, rd, ill, vld);          chk("rst mstatus", rd, 32'h1800);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      req_valid = ($urandom_range(0, 9) < 7);
      req_addr = addrs[$urandom_range(0, 27)];
      req_params.read_enable = 1'($urandom);
      req_params.write_enable = 1'($urandom);
      req_params.write_func = csr_write_func_e'($urandom_range(0, 3));
      req_params.input_select = 1'($urandom);
      req_params.write_value = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      instret_inc = 1'($urandom);
      trap_valid = ($urandom_range(0, 19) == 0);
      mret_valid = ($urandom_range(0, 19) == 0);
      trap_pc = $urandom; trap_cause = $urandom; trap_tval = $urandom;
      @(posedge clk);
      #1;
    end
    reset = 1'b0; req_valid = 1'b0; trap_valid = 1'b0; mret_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
